// File: rtl/cube_pkg.sv
// Shared types and defaults for the LED-cube layer shifter.
// The onehot helper covers cubes of up to MAX_LAYERS layers.
package cube_pkg;

   localparam int DEF_DATA_W  = 64;
   localparam int DEF_LAYERS  = 8;
   localparam int DEF_CLK_DIV = 4;
   localparam int MAX_LAYERS  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_BLANK = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   // Out-of-range indices give an all-zero drive so no layer is lit.
   function automatic logic [MAX_LAYERS-1:0] onehot(input int unsigned idx,
                                                    input int unsigned n);
      logic [MAX_LAYERS-1:0] v;
      v = '0;
      if (idx < n) begin
         v = {{(MAX_LAYERS-1){1'b0}}, 1'b1} << idx;
      end
      return v;
   endfunction

endpackage

// File: rtl/cube_tick_gen.sv
// Half-period phase counter for the shift clock: down-counts CLK_DIV cycles
// and flags the last cycle of each half-period; reloaded when a layer is accepted.
module cube_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= LOAD;
      end else if (i_clear) begin
         r_cnt <= LOAD;
      end else if (i_enable) begin
         if (r_cnt == '0) begin
            r_cnt <= LOAD;
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   assign o_tick = i_enable && (r_cnt == '0);

endmodule

// File: rtl/cube_layer_shifter.sv
// Serialises one cube layer into the column shift registers, latches it and
// switches the layer drive. Define CUBE_SHIFT_BLANK_EN to blank the columns
// and layers between shifting and latching (anti-ghosting).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a layer; previous layer stays lit
//   ST_SHIFT | clocking DATA_W bits out MSB-first, 2*CLK_DIV cycles/bit
//   ST_BLANK | columns off, layers off for CLK_DIV cycles (blank build)
//   ST_LATCH | storage-register latch high for CLK_DIV cycles
module cube_layer_shifter
   import cube_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LAYERS  = DEF_LAYERS,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic                       CLOCK_50,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [$clog2(LAYERS)-1:0]  in_layer,
   output logic                       sr_data,
   output logic                       sr_clk,
   output logic                       sr_latch,
   output logic                       sr_oe_n,
   output logic [LAYERS-1:0]          layer_en,
   output logic                       busy
);

   localparam int LW = $clog2(LAYERS);
   localparam int BW = $clog2(DATA_W);

   state_t             r_state;
   logic [DATA_W-1:0]  r_shreg;
   logic [LW-1:0]      r_layer;
   logic [BW-1:0]      r_bit_cnt;
   logic               r_in_ready;
   logic               r_sr_data;
   logic               r_sr_clk;
   logic               r_sr_latch;
   logic               r_sr_oe_n;
   logic [LAYERS-1:0]  r_layer_en;
   logic               r_busy;

   logic               w_accept;
   logic               w_tick;

   assign w_accept = in_valid && r_in_ready;

   cube_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk      (CLOCK_50),
      .rst_n    (rst_n),
      .i_clear  (w_accept),
      .i_enable (r_busy),
      .o_tick   (w_tick)
   );

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_shreg    <= '0;
         r_layer    <= '0;
         r_bit_cnt  <= '0;
         r_in_ready <= 1'b0;
         r_sr_data  <= 1'b0;
         r_sr_clk   <= 1'b0;
         r_sr_latch <= 1'b0;
         r_sr_oe_n  <= 1'b1;
         r_layer_en <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_state    <= ST_SHIFT;
                  r_shreg    <= in_data;
                  r_layer    <= in_layer;
                  r_bit_cnt  <= BW'(DATA_W - 1);
                  r_sr_data  <= in_data[DATA_W-1];
                  r_sr_clk   <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end

            ST_SHIFT: begin
               if (w_tick) begin
                  if (!r_sr_clk) begin
                     r_sr_clk <= 1'b1;
                  end else begin
                     r_sr_clk <= 1'b0;
                     if (r_bit_cnt == '0) begin
                        r_sr_data <= 1'b0;
`ifdef CUBE_SHIFT_BLANK_EN
                        r_state    <= ST_BLANK;
                        r_layer_en <= '0;
                        r_sr_oe_n  <= 1'b1;
`else
                        r_state    <= ST_LATCH;
                        r_sr_latch <= 1'b1;
`endif
                     end else begin
                        // r_shreg still holds the current bit at its MSB
                        r_bit_cnt <= r_bit_cnt - BW'(1);
                        r_sr_data <= r_shreg[DATA_W-2];
                        r_shreg   <= r_shreg << 1;
                     end
                  end
               end
            end

`ifdef CUBE_SHIFT_BLANK_EN
            ST_BLANK: begin
               if (w_tick) begin
                  r_state    <= ST_LATCH;
                  r_sr_latch <= 1'b1;
               end
            end
`endif

            ST_LATCH: begin
               if (w_tick) begin
                  r_state    <= ST_IDLE;
                  r_sr_latch <= 1'b0;
                  r_layer_en <= LAYERS'(onehot(32'(r_layer), 32'(LAYERS)));
                  r_sr_oe_n  <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               r_sr_clk   <= 1'b0;
               r_sr_latch <= 1'b0;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = r_in_ready;
   assign sr_data  = r_sr_data;
   assign sr_clk   = r_sr_clk;
   assign sr_latch = r_sr_latch;
   assign sr_oe_n  = r_sr_oe_n;
   assign layer_en = r_layer_en;
   assign busy     = r_busy;

endmodule
